// File: rtl/divider.sv
// divider: sequential restoring divider, one quotient bit per clock.
// Unsigned dividend (DIVIDEND_W bits) divided by unsigned divisor (DIVISOR_W bits),
// with a start/busy/done handshake. Results hold until the next accepted start.
// Optional feature macro: DIVIDER_DBZ_EN adds a dbz port. With it, a zero divisor
// skips iteration and reports done on the cycle after capture.
module divider #(
  parameter int DIVIDEND_W = 8,
  parameter int DIVISOR_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder
`ifdef DIVIDER_DBZ_EN
  ,
  output logic                  dbz
`endif
);

  localparam int CNT_W = $clog2(DIVIDEND_W + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DIVIDEND_W - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_nextState;

  logic [DIVIDEND_W-1:0] r_dvd;
  logic [DIVISOR_W-1:0]  r_divisor;
  logic [DIVISOR_W:0]    r_prem;
  logic [CNT_W-1:0]      r_cnt;
  logic [DIVIDEND_W-1:0] r_quotient;
  logic [DIVISOR_W-1:0]  r_remainder;

  logic                  w_accept;
  logic                  w_zeroSkip;
  logic                  w_lastStep;
  logic                  w_busy;
  logic                  w_done;
  logic [DIVISOR_W:0]    w_premShift;
  logic                  w_qBit;
  logic [DIVISOR_W:0]    w_premNext;
  logic [DIVIDEND_W-1:0] w_dvdNext;

`ifdef DIVIDER_DBZ_EN
  logic r_dbz;
  assign w_zeroSkip = (divisor == '0);
  assign dbz        = r_dbz;
`else
  assign w_zeroSkip = 1'b0;
`endif

  assign w_lastStep = (r_cnt == LAST_STEP);

  // One restoring step: shift the next dividend bit into the partial remainder,
  // subtract the divisor when it fits. The top partial-remainder bit is shifted out;
  // it is only ever set when the divisor is zero, where truncation is the intended result.
  assign w_premShift = (DIVISOR_W + 1)'({r_prem, r_dvd[DIVIDEND_W-1]});
  assign w_qBit      = (w_premShift >= {1'b0, r_divisor});
  assign w_premNext  = w_qBit ? (w_premShift - {1'b0, r_divisor}) : w_premShift;
  assign w_dvdNext   = DIVIDEND_W'({r_dvd, w_qBit});

  // State register; reset aborts any division in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state and handshake outputs; start is only honoured in IDLE or DONE.
  always_comb begin
    w_nextState = r_state;
    w_accept    = 1'b0;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_nextState = w_zeroSkip ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        w_busy = 1'b1;
        if (w_lastStep) begin
          w_nextState = S_DONE;
        end
      end
      S_DONE: begin
        w_done = 1'b1;
        if (start) begin
          w_accept    = 1'b1;
          w_nextState = w_zeroSkip ? S_DONE : S_CALC;
        end else begin
          w_nextState = S_IDLE;
        end
      end
      default: begin
        w_nextState = S_IDLE;
      end
    endcase
  end

  // Datapath: capture operands on accept, iterate in CALC, publish results on the last step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dvd       <= '0;
      r_divisor   <= '0;
      r_prem      <= '0;
      r_cnt       <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
    end else if (w_accept) begin
      r_dvd     <= dividend;
      r_divisor <= divisor;
      r_prem    <= '0;
      r_cnt     <= '0;
      if (w_zeroSkip) begin
        r_quotient  <= '1;
        r_remainder <= dividend[DIVISOR_W-1:0];
      end
    end else if (r_state == S_CALC) begin
      r_prem <= w_premNext;
      r_dvd  <= w_dvdNext;
      r_cnt  <= r_cnt + 1'b1;
      if (w_lastStep) begin
        r_quotient  <= w_dvdNext;
        r_remainder <= w_premNext[DIVISOR_W-1:0];
      end
    end
  end

`ifdef DIVIDER_DBZ_EN
  // Divide-by-zero flag: set when a zero divisor is accepted, cleared by any other accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dbz <= 1'b0;
    end else if (w_accept) begin
      r_dbz <= w_zeroSkip;
    end
  end
`endif

  assign busy      = w_busy;
  assign done      = w_done;
  assign quotient  = r_quotient;
  assign remainder = r_remainder;

endmodule

// File: tb/tb_divider.sv
// tb_divider: scoreboard bench for divider. Stimulus pushes expected results,
// an independent monitor pops them whenever done is seen.
module tb_divider;

  localparam int NORM_LAT = 8;
`ifdef DIVIDER_DBZ_EN
  localparam int DBZ_LAT = 0;
`else
  localparam int DBZ_LAT = 8;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] dividend = '0;
  logic [3:0] divisor = '0;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [3:0] remainder;
`ifdef DIVIDER_DBZ_EN
  logic       dbz;
`endif

  typedef struct {
    logic [7:0] q;
    logic [3:0] r;
    logic       z;
    int         cyc;
    int         busyCyc;
  } exp_t;

  exp_t expQ[$];
  int   cycleCount = 0;
  int   busyCount = 0;
  int   nChecks = 0;
  int   nFails = 0;

  divider #(.DIVIDEND_W(8), .DIVISOR_W(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .dividend(dividend),
    .divisor(divisor),
    .busy(busy),
    .done(done),
    .quotient(quotient),
    .remainder(remainder)
`ifdef DIVIDER_DBZ_EN
    ,
    .dbz(dbz)
`endif
  );

  always #5 clk = ~clk;

  // Count rising edges so the monitor can check done latency.
  always @(posedge clk) cycleCount <= cycleCount + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Called just after a falling edge; leaves start high for exactly one rising edge.
  task automatic applyStimulus(input logic [7:0] dd, input logic [3:0] dv, input logic [7:0] q,
                               input logic [3:0] r, input logic z, input int lat, input bit expectDone);
    exp_t e;
    dividend = dd;
    divisor  = dv;
    start    = 1'b1;
    if (expectDone) begin
      e.q = q;
      e.r = r;
      e.z = z;
      e.cyc = cycleCount + 1 + lat;
      e.busyCyc = lat;
      expQ.push_back(e);
    end
    @(negedge clk);
    start    = 1'b0;
    dividend = 8'($urandom);
    divisor  = 4'($urandom);
  endtask

  task automatic waitDone(input int maxCyc);
    int k = 0;
    while (!done && k < maxCyc) begin
      @(negedge clk);
      k++;
    end
    if (!done) begin
      nChecks++;
      nFails++;
      $display("[TB] FAIL done timeout: got no done within %0d cycles, expected a done pulse", maxCyc);
    end
  endtask

  // Monitor: compare each done pulse against the oldest expected result.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        busyCount = 0;
      end else if (done) begin
        if (expQ.size() == 0) begin
          nChecks++;
          nFails++;
          $display("[TB] FAIL unexpected done: got done=1 at cycle %0d, expected no pulse", cycleCount);
        end else begin
          e = expQ.pop_front();
          checkOutput("quotient", 32'(quotient), 32'(e.q));
          checkOutput("remainder", 32'(remainder), 32'(e.r));
          checkOutput("done cycle", 32'(cycleCount), 32'(e.cyc));
          checkOutput("busy cycles", 32'(busyCount), 32'(e.busyCyc));
          checkOutput("busy low with done", 32'(busy), 32'd0);
`ifdef DIVIDER_DBZ_EN
          checkOutput("dbz", 32'(dbz), 32'(e.z));
`endif
        end
        busyCount = 0;
      end else if (busy) begin
        busyCount++;
      end
    end
  end

  initial begin
    $display("[TB] divider scoreboard test starting");
    // Reset state, during and after reset.
    repeat (3) @(negedge clk);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset done", 32'(done), 32'd0);
    checkOutput("reset quotient", 32'(quotient), 32'd0);
    checkOutput("reset remainder", 32'(remainder), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("idle busy", 32'(busy), 32'd0);
    checkOutput("idle done", 32'(done), 32'd0);
`ifdef DIVIDER_DBZ_EN
    checkOutput("reset dbz", 32'(dbz), 32'd0);
`endif

    // Basic division.
    applyStimulus(8'd200, 4'd7, 8'd28, 4'd4, 1'b0, NORM_LAT, 1'b1);
    waitDone(20);
    @(negedge clk);

    // Largest operands, then quotient zero.
    applyStimulus(8'd255, 4'd15, 8'd17, 4'd0, 1'b0, NORM_LAT, 1'b1);
    waitDone(20);
    @(negedge clk);
    applyStimulus(8'd5, 4'd9, 8'd0, 4'd5, 1'b0, NORM_LAT, 1'b1);
    waitDone(20);
    @(negedge clk);

    // Start during CALC is ignored; results stay stable mid-iteration.
    applyStimulus(8'd100, 4'd7, 8'd14, 4'd2, 1'b0, NORM_LAT, 1'b1);
    repeat (2) @(negedge clk);
    dividend = 8'd10;
    divisor  = 4'd2;
    start    = 1'b1;
    checkOutput("held quotient in calc", 32'(quotient), 32'd0);
    checkOutput("held remainder in calc", 32'(remainder), 32'd5);
    @(negedge clk);
    start = 1'b0;
    waitDone(20);

    // Back-to-back starts issued in the done cycle.
    applyStimulus(8'd255, 4'd1, 8'd255, 4'd0, 1'b0, NORM_LAT, 1'b1);
    waitDone(20);
    applyStimulus(8'd13, 4'd13, 8'd1, 4'd0, 1'b0, NORM_LAT, 1'b1);
    waitDone(20);
    @(negedge clk);

    // Divide by zero.
    applyStimulus(8'hA5, 4'd0, 8'hFF, 4'h5, 1'b1, DBZ_LAT, 1'b1);
    waitDone(20);
    @(negedge clk);
`ifdef DIVIDER_DBZ_EN
    checkOutput("dbz held in idle", 32'(dbz), 32'd1);
`endif

    // Reset mid-division aborts with no done pulse.
    applyStimulus(8'd100, 4'd3, 8'd0, 4'd0, 1'b0, NORM_LAT, 1'b0);
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("abort busy", 32'(busy), 32'd0);
    checkOutput("abort done", 32'(done), 32'd0);
    checkOutput("abort quotient", 32'(quotient), 32'd0);
    checkOutput("abort remainder", 32'(remainder), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    applyStimulus(8'd100, 4'd3, 8'd33, 4'd1, 1'b0, NORM_LAT, 1'b1);
    waitDone(20);
    repeat (3) @(negedge clk);

    checkOutput("scoreboard drained", 32'(expQ.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
